f8_regbank: RTL and testbench
=============================

# f8_regbank

Parametrised, banked general-purpose register file for the next f8 core revision. It replaces the fixed 3×16-bit file and generalises register count, width and bank count. It provides two bypassed read ports, a byte-lane write port, single-cycle bank switching, and a sequenced bank-to-bank copy engine with busy/done handshake, used for fast interrupt context save. It sits between the decode/ALU datapath and the PC/address logic, which consumes the `rd_next_*` bypass values.

## Interface
- `NREGS`, 3, registers per bank (≥1)
- `WIDTH`, 16, register width in bits (multiple of 8)
- `NBANKS`, 2, number of banks (≥2)
- Derived: `AW` = max(1, clog2(NREGS)), `BW` = max(1, clog2(NBANKS)), `NB` = WIDTH/8

Ports:
- `clk`  in  1  clock; all state updates on posedge
- `reset`  in  1  synchronous, active-high
- `rd_addr_a`, `rd_addr_b`  in  AW  read port addresses (active bank)
- `rd_data_a`, `rd_data_b`  out  WIDTH  current register value, combinational
- `rd_next_a`, `rd_next_b`  out  WIDTH  value after this edge (write bypass), combinational
- `wr_addr`  in  AW  write address
- `wr_data`  in  WIDTH  write data
- `wr_be`  in  NB  byte-lane write enables; bit i covers data[8i+7:8i]
- `bank_sw_valid`  in  1  bank switch request
- `bank_sw_id`  in  BW  target bank
- `copy_start`  in  1  start copy of active bank to `copy_dst`
- `copy_dst`  in  BW  destination bank
- `active_bank`  out  BW  currently selected bank, registered
- `copy_busy`  out  1  copy engine not idle
- `copy_done`  out  1  one-cycle completion pulse
- `err`  out  1  one-cycle pulse, request rejected

## Operation
- Reads: `rd_data_x` = `bank[active_bank][rd_addr_x]`. An out-of-range address (≥ NREGS) reads 0.
- `rd_next_x`: per byte lane, `wr_data` if `wr_addr == rd_addr_x` and that lane of `wr_be` is set, else `rd_data_x`.
- Write: at posedge, the lanes selected by `wr_be` are written into `bank[active_bank][wr_addr]`.
  - An out-of-range `wr_addr` with `wr_be != 0` is dropped and raises `err`.
- Bank switch: `bank_sw_valid && bank_sw_id < NBANKS && !copy_busy` sets `active_bank <= bank_sw_id`.
  - A write in the same cycle targets the old bank.
  - Otherwise the request is ignored and raises `err`.
- Copy FSM, states IDLE, COPY, DONE:
  - IDLE → COPY on `copy_start` with `copy_dst < NBANKS`, `copy_dst != active_bank`, and state IDLE. This latches `src = active_bank`, `dst = copy_dst`, and `idx = 0`. An invalid `copy_start` raises `err` and stays in IDLE.
  - COPY: each edge does `bank[dst][idx] <= next value of bank[src][idx]` (includes a same-cycle write), then `idx++`. After `idx == NREGS-1` is copied, go to DONE.
  - DONE → IDLE unconditionally. `copy_done = (state == DONE)`.
- `copy_busy = (state != IDLE)`. A `copy_start` while busy raises `err` and is ignored.
- Writes continue during a copy and only ever hit the active (source) bank. A write to register j lands in dst only if it occurs no later than the cycle j is copied.
- `err` is registered: it asserts the cycle after any rejection. Multiple rejections in one cycle produce a single pulse.

## Timing
- Reset values:
  - all registers in all banks 0
  - `active_bank` 0
  - FSM IDLE
  - `copy_busy`, `copy_done`, `err` all 0
- Read latency 0; write-to-read visibility: the cycle after the edge (same cycle via `rd_next`).
- Copy accepted at edge E0: `copy_busy` is high in cycles E0+1 … E0+NREGS+1. `copy_done` is high in cycle E0+NREGS+1 only. A new `copy_start` is accepted at edge E0+NREGS+2 at the earliest.
- Reset asserted mid-copy aborts the copy and clears everything at that edge. No `copy_done` is produced.
- Simultaneous `bank_sw_valid` and a valid `copy_start` in IDLE: both take effect. The copy source is the pre-switch bank. If `copy_dst` equals the new bank, that is legal.

## Test plan
- Defaults apply. Reset, then read r0–r2 → 0; `active_bank` = 0; `err` = 0.
- Write r1 = 0xAA55 with `wr_be` = 01, then 10 with `wr_data` 0x1234 → `rd_next` shows 0x0055 then 0x1255 in the same cycle; `rd_data_a` = 0x1255 the next cycle.
- Bank 0 holds r0 = 0x0201, r1 = 0x0100, r2 = 0xAA55. `copy_start`, `copy_dst` = 1 → busy for 4 cycles, done on the 4th. Then switch to bank 1 and read back the same three values.
- During a copy, write r2 = 0xFFFF in the cycle r2 is copied → bank 1 r2 = 0xFFFF. Write r0 = 0x1111 after r0 is copied → bank 1 r0 unchanged, bank 0 r0 = 0x1111.
- Each of these produces a single-cycle `err` with state unchanged:
  - `bank_sw_valid` while busy
  - `copy_dst` = `active_bank`
  - `bank_sw_id` = 2
  - write to address 3
- Assert `reset` on the 2nd copy cycle → `copy_busy` 0 next cycle, no `copy_done`, all registers 0, `active_bank` 0.

Source files
------------

// File: rtl/f8_regbank.sv
// rtl/f8_regbank.sv - banked register file with bypassed reads, byte-lane writes and bank copy engine
//
// Purpose: NBANKS banks of NREGS x WIDTH registers; one bank is active at a time.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   rd_addr_a/b -> rd_data_a/b combinational reads of the active bank (out of range reads 0)
//   rd_next_a/b                read value with this cycle's write bypassed in per byte lane
//   wr_addr, wr_data, wr_be    byte-lane write into the active bank
//   bank_sw_valid, bank_sw_id  select a new active bank (rejected while copying)
//   copy_start, copy_dst       copy the active bank into copy_dst, one register per cycle
//   active_bank                currently selected bank
//   copy_busy, copy_done       copy engine not idle / one-cycle completion pulse
//   err                        one-cycle pulse, the cycle after any rejected request
module f8_regbank #(
  parameter int NREGS  = 3,
  parameter int WIDTH  = 16,
  parameter int NBANKS = 2,
  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1,
  localparam int BW = (NBANKS > 1) ? $clog2(NBANKS) : 1,
  localparam int NB = WIDTH / 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic [WIDTH-1:0] rd_next_a,
  output logic [WIDTH-1:0] rd_next_b,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [NB-1:0]    wr_be,
  input  logic             bank_sw_valid,
  input  logic [BW-1:0]    bank_sw_id,
  input  logic             copy_start,
  input  logic [BW-1:0]    copy_dst,
  output logic [BW-1:0]    active_bank,
  output logic             copy_busy,
  output logic             copy_done,
  output logic             err
);

  localparam logic [AW:0]   NREGS_W  = (AW+1)'(NREGS);
  localparam logic [BW:0]   NBANKS_W = (BW+1)'(NBANKS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_COPY, ST_DONE} state_t;

  state_t           state_q;
  logic [BW-1:0]    active_q;
  logic [BW-1:0]    src_q;
  logic [BW-1:0]    dst_q;
  logic [AW-1:0]    idx_q;
  logic             err_q;
  logic [WIDTH-1:0] regs_q [NBANKS][NREGS];

  logic [WIDTH-1:0] wr_mask;
  logic             rd_ok_a, rd_ok_b, wr_ok;
  logic [AW-1:0]    rd_idx_a, rd_idx_b, wr_idx;
  logic             wr_en, sw_accept, copy_accept, reject;
  logic             copy_hit;
  logic [WIDTH-1:0] wr_val, copy_val;

  function automatic logic [WIDTH-1:0] lane_merge(input logic [WIDTH-1:0] old_v,
                                                  input logic [WIDTH-1:0] new_v,
                                                  input logic [WIDTH-1:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  for (genvar i = 0; i < NB; i++) begin : g_mask
    assign wr_mask[8*i +: 8] = {8{wr_be[i]}};
  end

  // Out-of-range addresses are clamped to 0 so the array is never indexed past its end.
  assign rd_ok_a  = {1'b0, rd_addr_a} < NREGS_W;
  assign rd_ok_b  = {1'b0, rd_addr_b} < NREGS_W;
  assign wr_ok    = {1'b0, wr_addr} < NREGS_W;
  assign rd_idx_a = rd_ok_a ? rd_addr_a : '0;
  assign rd_idx_b = rd_ok_b ? rd_addr_b : '0;
  assign wr_idx   = wr_ok ? wr_addr : '0;

  assign rd_data_a = rd_ok_a ? regs_q[active_q][rd_idx_a] : '0;
  assign rd_data_b = rd_ok_b ? regs_q[active_q][rd_idx_b] : '0;
  assign rd_next_a = (wr_addr == rd_addr_a) ? lane_merge(rd_data_a, wr_data, wr_mask) : rd_data_a;
  assign rd_next_b = (wr_addr == rd_addr_b) ? lane_merge(rd_data_b, wr_data, wr_mask) : rd_data_b;

  assign wr_en  = wr_ok && (wr_be != '0);
  assign wr_val = lane_merge(regs_q[active_q][wr_idx], wr_data, wr_mask);

  // The copied value is the source register as it will be after this edge,
  // so a write landing in the same cycle is carried into the destination.
  assign copy_hit = wr_en && (active_q == src_q) && (wr_addr == idx_q);
  assign copy_val = copy_hit ? wr_val : regs_q[src_q][idx_q];

  assign sw_accept   = bank_sw_valid && ({1'b0, bank_sw_id} < NBANKS_W) && (state_q == ST_IDLE);
  assign copy_accept = copy_start && (state_q == ST_IDLE) &&
                       ({1'b0, copy_dst} < NBANKS_W) && (copy_dst != active_q);
  assign reject      = ((wr_be != '0) && !wr_ok) ||
                       (bank_sw_valid && !sw_accept) ||
                       (copy_start && !copy_accept);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      active_q <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
      for (int b = 0; b < NBANKS; b++) begin
        for (int r = 0; r < NREGS; r++) begin
          regs_q[b][r] <= '0;
        end
      end
    end else begin
      err_q <= reject;
      // Write uses the pre-switch bank; a switch in the same cycle only affects later cycles.
      if (wr_en) regs_q[active_q][wr_idx] <= wr_val;
      if (sw_accept) active_q <= bank_sw_id;
      case (state_q)
        ST_IDLE: begin
          if (copy_accept) begin
            state_q <= ST_COPY;
            src_q   <= active_q;
            dst_q   <= copy_dst;
            idx_q   <= '0;
          end
        end
        ST_COPY: begin
          regs_q[dst_q][idx_q] <= copy_val;
          if (idx_q == LAST_IDX) state_q <= ST_DONE;
          else                   idx_q   <= idx_q + AW'(1);
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign active_bank = active_q;
  assign copy_busy   = (state_q != ST_IDLE);
  assign copy_done   = (state_q == ST_DONE);
  assign err         = err_q;

endmodule

// File: tb/tb_f8_regbank.sv
// tb/tb_f8_regbank.sv - self-checking bench for f8_regbank
module tb_f8_regbank;

  localparam int NREGS = 3, WIDTH = 16, NBANKS = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  rd_addr_a, rd_addr_b, wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;
  logic        bank_sw_valid;
  logic [0:0]  bank_sw_id;
  logic        copy_start;
  logic [0:0]  copy_dst;
  logic [15:0] rd_data_a, rd_data_b, rd_next_a, rd_next_b;
  logic [0:0]  active_bank;
  logic        copy_busy, copy_done, err;

  logic        sw3_valid;
  logic [1:0]  sw3_id;
  logic [15:0] d3_rda, d3_rdb, d3_rna, d3_rnb;
  logic [1:0]  d3_active;
  logic        d3_busy, d3_done, d3_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  f8_regbank #(.NREGS(NREGS), .WIDTH(WIDTH), .NBANKS(NBANKS)) u_dut (
    .clk(clk), .reset(reset),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .rd_next_a(rd_next_a), .rd_next_b(rd_next_b),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .bank_sw_valid(bank_sw_valid), .bank_sw_id(bank_sw_id),
    .copy_start(copy_start), .copy_dst(copy_dst),
    .active_bank(active_bank), .copy_busy(copy_busy), .copy_done(copy_done), .err(err)
  );

  // Three-bank instance: lets an out-of-range bank id be expressed.
  f8_regbank #(.NREGS(3), .WIDTH(16), .NBANKS(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .rd_addr_a(2'd0), .rd_addr_b(2'd0),
    .rd_data_a(d3_rda), .rd_data_b(d3_rdb),
    .rd_next_a(d3_rna), .rd_next_b(d3_rnb),
    .wr_addr(2'd0), .wr_data(16'h0), .wr_be(2'b00),
    .bank_sw_valid(sw3_valid), .bank_sw_id(sw3_id),
    .copy_start(1'b0), .copy_dst(2'd0),
    .active_bank(d3_active), .copy_busy(d3_busy), .copy_done(d3_done), .err(d3_err)
  );

  // ---------------- reference model ----------------
  logic [15:0] m_regs [NBANKS][NREGS];
  int m_active, m_acc, m_src, m_dst, cyc;
  bit m_err;

  function automatic logic [15:0] merge(input logic [15:0] old_v, input logic [15:0] new_v,
                                        input logic [1:0] be);
    logic [15:0] r;
    r = old_v;
    for (int b = 0; b < 16; b++) if (be[b/8]) r[b] = new_v[b];
    return r;
  endfunction

  function automatic logic [15:0] m_read(input int addr);
    return (addr < NREGS) ? m_regs[m_active][addr] : 16'h0;
  endfunction

  function automatic logic [15:0] m_next(input int addr);
    return (addr == int'(wr_addr)) ? merge(m_read(addr), wr_data, wr_be) : m_read(addr);
  endfunction

  function automatic bit m_busy();
    return (m_acc >= 0) && (cyc >= m_acc + 1) && (cyc <= m_acc + NREGS + 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < NBANKS; b++) for (int r = 0; r < NREGS; r++) m_regs[b][r] = 16'h0;
    m_active = 0; m_acc = -100; m_src = 0; m_dst = 0; m_err = 0; cyc = 0;
  endtask

  task automatic model_check();
    chk("m_rd_data_a", rd_data_a, m_read(rd_addr_a));
    chk("m_rd_data_b", rd_data_b, m_read(rd_addr_b));
    chk("m_rd_next_a", rd_next_a, m_next(rd_addr_a));
    chk("m_rd_next_b", rd_next_b, m_next(rd_addr_b));
    chk("m_active", active_bank, m_active);
    chk("m_busy", copy_busy, m_busy());
    chk("m_done", copy_done, (m_acc >= 0) && (cyc == m_acc + NREGS + 1));
    chk("m_err", err, m_err);
  endtask

  task automatic model_edge();
    logic [15:0] nxt [NBANKS][NREGS];
    bit busy, rej;
    int new_act, j;
    nxt = m_regs;
    busy = m_busy();
    rej = 0;
    new_act = m_active;
    if (wr_be != 0) begin
      if (wr_addr < NREGS) nxt[m_active][wr_addr] = merge(m_regs[m_active][wr_addr], wr_data, wr_be);
      else rej = 1;
    end
    if (busy && cyc <= m_acc + NREGS) begin
      j = cyc - m_acc - 1;
      nxt[m_dst][j] = nxt[m_src][j];
    end
    if (bank_sw_valid) begin
      if (bank_sw_id < NBANKS && !busy) new_act = bank_sw_id;
      else rej = 1;
    end
    if (copy_start) begin
      if (!busy && copy_dst < NBANKS && int'(copy_dst) != m_active) begin
        m_acc = cyc; m_src = m_active; m_dst = copy_dst;
      end else rej = 1;
    end
    m_regs = nxt;
    m_active = new_act;
    m_err = rej;
    cyc++;
  endtask

  task automatic set_idle();
    rd_addr_a = 0; rd_addr_b = 0; wr_addr = 0; wr_data = 0; wr_be = 0;
    bank_sw_valid = 0; bank_sw_id = 0; copy_start = 0; copy_dst = 0;
    sw3_valid = 0; sw3_id = 0;
  endtask

  task automatic step();
    @(negedge clk);
    model_check();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic read_bank(input string name, input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2);
    rd_addr_a = 0; rd_addr_b = 1; #1;
    chk({name, "_r0"}, rd_data_a, e0);
    chk({name, "_r1"}, rd_data_b, e1);
    rd_addr_a = 2; #1;
    chk({name, "_r2"}, rd_data_a, e2);
  endtask

  typedef struct {
    logic [1:0]  wa, be;
    logic [15:0] wd;
    logic [1:0]  ra, rb;
    logic        sw;
    logic [0:0]  sid;
    logic [15:0] e_da, e_na, e_nb;
    logic [0:0]  e_act;
    logic        e_err;
  } vec_t;

  vec_t vecs [19];

  initial begin
    vecs = '{
      '{2'd0, 2'b00, 16'h0000, 2'd0, 2'd1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0},
      '{2'd0, 2'b00, 16'h0000, 2'd2, 2'd3, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0},
      '{2'd1, 2'b01, 16'hAA55, 2'd1, 2'd0, 1'b0, 1'b0, 16'h0000, 16'h0055, 16'h0000, 1'b0, 1'b0},
      '{2'd1, 2'b10, 16'h1234, 2'd1, 2'd2, 1'b0, 1'b0, 16'h0055, 16'h1255, 16'h0000, 1'b0, 1'b0},
      '{2'd0, 2'b00, 16'h0000, 2'd1, 2'd1, 1'b0, 1'b0, 16'h1255, 16'h1255, 16'h1255, 1'b0, 1'b0},
      '{2'd0, 2'b11, 16'h0201, 2'd0, 2'd1, 1'b0, 1'b0, 16'h0000, 16'h0201, 16'h1255, 1'b0, 1'b0},
      '{2'd1, 2'b11, 16'h0100, 2'd1, 2'd0, 1'b0, 1'b0, 16'h1255, 16'h0100, 16'h0201, 1'b0, 1'b0},
      '{2'd2, 2'b11, 16'hAA55, 2'd2, 2'd1, 1'b0, 1'b0, 16'h0000, 16'hAA55, 16'h0100, 1'b0, 1'b0},
      '{2'd3, 2'b11, 16'hFFFF, 2'd0, 2'd2, 1'b0, 1'b0, 16'h0201, 16'h0201, 16'hAA55, 1'b0, 1'b0},
      '{2'd0, 2'b00, 16'h0000, 2'd0, 2'd3, 1'b0, 1'b0, 16'h0201, 16'h0201, 16'h0000, 1'b0, 1'b1},
      '{2'd0, 2'b00, 16'h0000, 2'd3, 2'd2, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hAA55, 1'b0, 1'b0},
      '{2'd0, 2'b00, 16'h0000, 2'd0, 2'd1, 1'b1, 1'b1, 16'h0201, 16'h0201, 16'h0100, 1'b0, 1'b0},
      '{2'd0, 2'b00, 16'h0000, 2'd0, 2'd1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0},
      '{2'd0, 2'b00, 16'h0000, 2'd0, 2'd2, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0},
      '{2'd2, 2'b11, 16'h5A5A, 2'd2, 2'd0, 1'b1, 1'b1, 16'hAA55, 16'h5A5A, 16'h0201, 1'b0, 1'b0},
      '{2'd0, 2'b00, 16'h0000, 2'd2, 2'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0},
      '{2'd0, 2'b00, 16'h0000, 2'd2, 2'd0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0},
      '{2'd2, 2'b11, 16'hAA55, 2'd2, 2'd0, 1'b0, 1'b0, 16'h5A5A, 16'hAA55, 16'h0201, 1'b0, 1'b0},
      '{2'd0, 2'b00, 16'h0000, 2'd2, 2'd1, 1'b0, 1'b0, 16'hAA55, 16'hAA55, 16'h0100, 1'b0, 1'b0}
    };

    set_idle();
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    model_reset();

    // Reset state
    #1;
    chk("rst_busy", copy_busy, 0);
    chk("rst_done", copy_done, 0);
    chk("rst_err", err, 0);
    chk("rst_active", active_bank, 0);

    // Table: reads, byte-lane writes, bypass, bad address, bank switch with write
    for (int i = 0; i < 19; i++) begin
      wr_addr = vecs[i].wa; wr_be = vecs[i].be; wr_data = vecs[i].wd;
      rd_addr_a = vecs[i].ra; rd_addr_b = vecs[i].rb;
      bank_sw_valid = vecs[i].sw; bank_sw_id = vecs[i].sid;
      #1;
      chk($sformatf("vec%0d_data_a", i), rd_data_a, vecs[i].e_da);
      chk($sformatf("vec%0d_next_a", i), rd_next_a, vecs[i].e_na);
      chk($sformatf("vec%0d_next_b", i), rd_next_b, vecs[i].e_nb);
      chk($sformatf("vec%0d_active", i), active_bank, vecs[i].e_act);
      chk($sformatf("vec%0d_err", i), err, vecs[i].e_err);
      step();
    end
    set_idle();

    // Plain copy bank0 -> bank1: busy for NREGS+1 cycles, done on the last
    copy_start = 1; copy_dst = 1; #1;
    chk("cp1_busy_pre", copy_busy, 0);
    step();
    set_idle();
    for (int k = 1; k <= 4; k++) begin
      #1;
      chk($sformatf("cp1_busy_c%0d", k), copy_busy, 1);
      chk($sformatf("cp1_done_c%0d", k), copy_done, k == 4);
      step();
    end
    #1;
    chk("cp1_busy_post", copy_busy, 0);
    chk("cp1_done_post", copy_done, 0);
    bank_sw_valid = 1; bank_sw_id = 1; step(); set_idle();
    read_bank("cp1_b1", 16'h0201, 16'h0100, 16'hAA55);
    bank_sw_valid = 1; bank_sw_id = 0; step(); set_idle();

    // Copy with concurrent writes and rejected requests
    copy_start = 1; copy_dst = 1; step(); set_idle();
    bank_sw_valid = 1; bank_sw_id = 1; step(); set_idle();
    #1;
    chk("cp2_err_sw_busy", err, 1);
    chk("cp2_active_kept", active_bank, 0);
    wr_addr = 0; wr_data = 16'h1111; wr_be = 2'b11;
    copy_start = 1; copy_dst = 1;
    step(); set_idle();
    #1;
    chk("cp2_err_start_busy", err, 1);
    wr_addr = 2; wr_data = 16'hFFFF; wr_be = 2'b11;
    step(); set_idle();
    #1;
    chk("cp2_done", copy_done, 1);
    chk("cp2_err_clear", err, 0);
    step();
    read_bank("cp2_b0", 16'h1111, 16'h0100, 16'hFFFF);
    bank_sw_valid = 1; bank_sw_id = 1; step(); set_idle();
    read_bank("cp2_b1", 16'h0201, 16'h0100, 16'hFFFF);

    // copy_dst == active_bank is rejected
    copy_start = 1; copy_dst = 1; step(); set_idle();
    #1;
    chk("dst_eq_err", err, 1);
    chk("dst_eq_busy", copy_busy, 0);
    step();

    // Switch and copy together: source is the pre-switch bank (1), dst is the new bank (0)
    bank_sw_valid = 1; bank_sw_id = 0; copy_start = 1; copy_dst = 0;
    step(); set_idle();
    #1;
    chk("swcp_active", active_bank, 0);
    chk("swcp_busy", copy_busy, 1);
    chk("swcp_err", err, 0);
    repeat (4) step();
    read_bank("swcp_b0", 16'h0201, 16'h0100, 16'hFFFF);

    // Reset on the second copy cycle aborts everything
    copy_start = 1; copy_dst = 1; step(); set_idle();
    step();
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    model_reset();
    #1;
    chk("rstcp_busy", copy_busy, 0);
    chk("rstcp_done", copy_done, 0);
    chk("rstcp_active", active_bank, 0);
    read_bank("rstcp_b0", 16'h0, 16'h0, 16'h0);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("rstcp_nodone_%0d", k), copy_done, 0);
      step();
    end
    bank_sw_valid = 1; bank_sw_id = 1; step(); set_idle();
    read_bank("rstcp_b1", 16'h0, 16'h0, 16'h0);

    // Out-of-range bank id on the three-bank instance
    sw3_valid = 1; sw3_id = 2'd3; step();
    sw3_id = 2'd2; #1;
    chk("b3_err_bad_id", d3_err, 1);
    chk("b3_active_kept", d3_active, 0);
    step();
    sw3_valid = 0; #1;
    chk("b3_active_new", d3_active, 2);
    chk("b3_err_clear", d3_err, 0);
    step();

    // Randomised run against the model
    for (int n = 0; n < 3000; n++) begin
      rd_addr_a = 2'($urandom_range(0, 3));
      rd_addr_b = 2'($urandom_range(0, 3));
      wr_addr   = 2'($urandom_range(0, 3));
      wr_data   = 16'($urandom);
      wr_be     = 2'($urandom_range(0, 3));
      copy_start = ($urandom_range(0, 9) == 0);
      copy_dst   = 1'($urandom_range(0, 1));
      bank_sw_valid = !copy_start && ($urandom_range(0, 7) == 0);
      bank_sw_id    = 1'($urandom_range(0, 1));
      step();
    end
    set_idle();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
